// File: rtl/run_mon_pkg.sv
// ---------------------------------------------------------------------------
// run_mon_pkg
// Shared constants and types for the run event monitor slice.
//   POL_ZERO / POL_ONE : run polarity encoding (1 = run of ones)
//   run_state_t        : run-tracker FSM states
//   LEN_W_DEF/CNT_W_DEF: default run-length and counter widths
// Event records are packed {pol, len}, with pol as the MSB.
// ---------------------------------------------------------------------------
package run_mon_pkg;

   localparam logic POL_ZERO = 1'b0;
   localparam logic POL_ONE  = 1'b1;

   localparam int unsigned LEN_W_DEF = 8;
   localparam int unsigned CNT_W_DEF = 16;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } run_state_t;

endpackage

// File: rtl/run_evt_fifo.sv
// ---------------------------------------------------------------------------
// run_evt_fifo
// Synchronous DEPTH x W FIFO holding run event records. Pointers carry one
// extra wrap bit so full and empty are distinguished without a counter.
// A push into a full FIFO is accepted only when a pop happens on the same
// edge; otherwise it is ignored.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   i_push        : write request
//   i_push_data   : record to write
//   i_pop         : read request (ignored while empty)
//   o_head_data   : record at the head of the queue
//   o_full        : no free entries
//   o_empty       : no stored entries
// ---------------------------------------------------------------------------
module run_evt_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 9
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_push,
   input  logic [W-1:0] i_push_data,
   input  logic         i_pop,
   output logic [W-1:0] o_head_data,
   output logic         o_full,
   output logic         o_empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]  r_wr_ptr;
   logic [AW:0]  r_rd_ptr;
   logic [W-1:0] r_mem [DEPTH];

   logic w_do_pop;
   logic w_do_push;

   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

   assign w_do_pop  = i_pop && !o_empty;
   // A same-edge pop frees the slot the push needs.
   assign w_do_push = i_push && (!o_full || w_do_pop);

   assign o_head_data = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
            r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/run_event_monitor.sv
// ---------------------------------------------------------------------------
// run_event_monitor
// Watches the three-in-a-row detector output (det_y) alongside the serial
// stream (x_in). Each completed run of >= 3 identical bits is measured and
// pushed as a {pol, len} record into an event FIFO with a valid/ready read
// port. Also keeps per-polarity saturating run counters and a sticky
// overflow flag for records dropped on a full FIFO.
// Optional feature: define RUN_MON_MAXLEN_EN to track the longest pushed
// run length on max_len; otherwise max_len is tied to 0.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   x_in                 : serial bit stream
//   det_y                : detector output, high while run >= 3
//   clr                  : clear counters, overflow and max_len
//   evt_valid/evt_ready  : FIFO head handshake
//   evt_pol/evt_len      : FIFO head record
//   ones_cnt/zeros_cnt   : pushed runs per polarity
//   overflow             : sticky record-dropped flag
//   max_len              : longest pushed run length
// ---------------------------------------------------------------------------
module run_event_monitor
   import run_mon_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned LEN_W = LEN_W_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             x_in,
   input  logic             det_y,
   input  logic             clr,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic             evt_pol,
   output logic [LEN_W-1:0] evt_len,
   output logic [CNT_W-1:0] ones_cnt,
   output logic [CNT_W-1:0] zeros_cnt,
   output logic             overflow,
   output logic [LEN_W-1:0] max_len
);

   run_state_t       r_state;
   logic             r_x_q;
   logic             r_y_q;
   logic [LEN_W-1:0] r_hi_cnt;
   logic             r_pol;
   logic [CNT_W-1:0] r_ones_cnt;
   logic [CNT_W-1:0] r_zeros_cnt;
   logic             r_overflow;

   logic             w_run_end;
   logic [LEN_W:0]   w_len_sum;
   logic [LEN_W-1:0] w_len;
   logic             w_full;
   logic             w_empty;
   logic             w_pop;
   logic             w_push_ok;
   logic [LEN_W:0]   w_head;

   // The detector is high for (run length - 2) cycles, so add the two
   // leading bits back, saturating at all-ones.
   assign w_len_sum = {1'b0, r_hi_cnt} + (LEN_W+1)'(2);
   assign w_len     = w_len_sum[LEN_W] ? '1 : w_len_sum[LEN_W-1:0];

   assign w_run_end = (r_state == ST_RUN) && r_y_q && !det_y;
   assign w_pop     = evt_ready && !w_empty;
   assign w_push_ok = w_run_end && (!w_full || w_pop);

   // Run-tracker FSM
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_x_q    <= 1'b0;
         r_y_q    <= 1'b0;
         r_hi_cnt <= '0;
         r_pol    <= POL_ZERO;
      end else begin
         r_x_q <= x_in;
         r_y_q <= det_y;
         case (r_state)
            ST_IDLE: begin
               if (det_y) begin
                  r_state  <= ST_RUN;
                  r_hi_cnt <= LEN_W'(1);
                  // x_q holds the bit that completed the third repeat.
                  r_pol    <= r_x_q;
               end
            end
            ST_RUN: begin
               if (det_y) begin
                  if (r_hi_cnt != '1) begin
                     r_hi_cnt <= r_hi_cnt + LEN_W'(1);
                  end
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Counters and overflow; clr takes priority over a same-edge run end.
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         r_ones_cnt  <= '0;
         r_zeros_cnt <= '0;
         r_overflow  <= 1'b0;
      end else if (w_run_end) begin
         if (w_push_ok) begin
            if (r_pol == POL_ONE) begin
               if (r_ones_cnt != '1) r_ones_cnt <= r_ones_cnt + CNT_W'(1);
            end else begin
               if (r_zeros_cnt != '1) r_zeros_cnt <= r_zeros_cnt + CNT_W'(1);
            end
         end else begin
            r_overflow <= 1'b1;
         end
      end
   end

   run_evt_fifo #(
      .DEPTH (DEPTH),
      .W     (LEN_W + 1)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .i_push      (w_push_ok),
      .i_push_data ({r_pol, w_len}),
      .i_pop       (w_pop),
      .o_head_data (w_head),
      .o_full      (w_full),
      .o_empty     (w_empty)
   );

   assign evt_valid = !w_empty;
   assign evt_pol   = w_head[LEN_W];
   assign evt_len   = w_head[LEN_W-1:0];
   assign ones_cnt  = r_ones_cnt;
   assign zeros_cnt = r_zeros_cnt;
   assign overflow  = r_overflow;

`ifdef RUN_MON_MAXLEN_EN
   logic [LEN_W-1:0] r_max_len;

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         r_max_len <= '0;
      end else if (w_push_ok && (w_len > r_max_len)) begin
         r_max_len <= w_len;
      end
   end

   assign max_len = r_max_len;
`else
   assign max_len = '0;
`endif

endmodule

// File: tb/tb_run_event_monitor.sv
// ---------------------------------------------------------------------------
// tb_run_event_monitor
// Directed bench for run_event_monitor. A behavioural three-in-a-row
// detector drives det_y from x_in; expected event records are queued as
// stimulus is planned and compared whenever the DUT hands one over.
// ---------------------------------------------------------------------------
module tb_run_event_monitor;

`ifdef RUN_MON_MAXLEN_EN
   localparam bit MAXLEN_ON = 1'b1;
`else
   localparam bit MAXLEN_ON = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic        x_in;
   logic        det_y;
   logic        clr;
   logic        evt_valid;
   logic        evt_ready;
   logic        evt_pol;
   logic [7:0]  evt_len;
   logic [15:0] ones_cnt;
   logic [15:0] zeros_cnt;
   logic        overflow;
   logic [7:0]  max_len;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   logic [8:0]  sb[$];
   logic        last_bit;

   run_event_monitor #(
      .DEPTH (4),
      .LEN_W (8),
      .CNT_W (16)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .x_in      (x_in),
      .det_y     (det_y),
      .clr       (clr),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .evt_pol   (evt_pol),
      .evt_len   (evt_len),
      .ones_cnt  (ones_cnt),
      .zeros_cnt (zeros_cnt),
      .overflow  (overflow),
      .max_len   (max_len)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural Moore three-in-a-row detector.
   int unsigned m_cnt;
   logic        m_prev;
   always @(posedge clk) begin
      if (reset) begin
         m_cnt  <= 0;
         m_prev <= 1'b0;
      end else begin
         if (m_cnt != 0 && x_in == m_prev) m_cnt <= m_cnt + 1;
         else                              m_cnt <= 1;
         m_prev <= x_in;
      end
   end
   assign det_y = (m_cnt >= 3);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drive one bit for one cycle; a head record that is accepted at the
   // coming edge is checked against the scoreboard.
   task automatic step(input logic b);
      logic [8:0] exp;
      x_in     = b;
      last_bit = b;
      if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
         chk("rec_avail", 32'(evt_valid), 32'(sb.size() != 0));
         if (sb.size() != 0) begin
            exp = sb.pop_front();
            chk("rec", {23'b0, evt_pol, evt_len}, {23'b0, exp});
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_bits(input logic b, input int n);
      for (int i = 0; i < n; i++) step(b);
   endtask

   // Alternating bits never form a run, starting opposite the last bit.
   task automatic flush(input int n);
      logic b;
      b = ~last_bit;
      for (int i = 0; i < n; i++) begin
         step(b);
         b = ~b;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(1'b0);
      step(1'b0);
      reset = 1'b0;
   endtask

   task automatic chk_reset_vals(input string pfx);
      chk({pfx, "_valid"},    32'(evt_valid), 32'd0);
      chk({pfx, "_pol"},      32'(evt_pol),   32'd0);
      chk({pfx, "_len"},      32'(evt_len),   32'd0);
      chk({pfx, "_ones"},     32'(ones_cnt),  32'd0);
      chk({pfx, "_zeros"},    32'(zeros_cnt), 32'd0);
      chk({pfx, "_overflow"}, 32'(overflow),  32'd0);
      chk({pfx, "_max_len"},  32'(max_len),   32'd0);
   endtask

   task automatic chk_drained(input string pfx);
      chk({pfx, "_sb_left"}, 32'(sb.size()), 32'd0);
      chk({pfx, "_valid"},   32'(evt_valid), 32'd0);
   endtask

   initial begin
      reset     = 1'b1;
      x_in      = 1'b0;
      clr       = 1'b0;
      evt_ready = 1'b0;
      last_bit  = 1'b0;

      // Reset state
      do_reset();
      chk_reset_vals("rst");

      // Run of three ones, with latency check
      evt_ready = 1'b1;
      sb.push_back({1'b1, 8'd3});
      step(1'b0); step(1'b1); step(1'b1); step(1'b1); step(1'b0);
      chk("lat_pre_valid", 32'(evt_valid), 32'd0);
      step(1'b0);
      chk("lat_valid", 32'(evt_valid), 32'd1);
      flush(6);
      chk("t1_ones",  32'(ones_cnt),  32'd1);
      chk("t1_zeros", 32'(zeros_cnt), 32'd0);
      chk("t1_ovf",   32'(overflow),  32'd0);
      chk_drained("t1");

      // Run of five zeros, max_len, then clr
      do_reset();
      evt_ready = 1'b1;
      sb.push_back({1'b0, 8'd5});
      run_bits(1'b0, 5);
      step(1'b1);
      flush(6);
      chk("t2_zeros", 32'(zeros_cnt), 32'd1);
      chk("t2_ones",  32'(ones_cnt),  32'd0);
      chk("t2_max",   32'(max_len),   MAXLEN_ON ? 32'd5 : 32'd0);
      chk_drained("t2");
      clr = 1'b1;
      flush(1);
      clr = 1'b0;
      chk("t2_clr_zeros", 32'(zeros_cnt), 32'd0);
      chk("t2_clr_max",   32'(max_len),   32'd0);

      // Long run saturates the length field
      do_reset();
      evt_ready = 1'b1;
      sb.push_back({1'b1, 8'd255});
      run_bits(1'b1, 300);
      flush(6);
      chk("t3_ones", 32'(ones_cnt), 32'd1);
      chk("t3_max",  32'(max_len),  MAXLEN_ON ? 32'd255 : 32'd0);
      chk_drained("t3");

      // clr on the same edge as a run end: record kept, counter cleared
      do_reset();
      evt_ready = 1'b1;
      sb.push_back({1'b1, 8'd3});
      run_bits(1'b1, 3);
      step(1'b0);
      clr = 1'b1;
      step(1'b1);
      clr = 1'b0;
      flush(4);
      chk("t7_ones", 32'(ones_cnt), 32'd0);
      chk("t7_ovf",  32'(overflow), 32'd0);
      chk_drained("t7");

      // Overflow: five runs into a depth-4 FIFO with no consumer
      do_reset();
      evt_ready = 1'b0;
      sb.push_back({1'b1, 8'd3});
      sb.push_back({1'b0, 8'd3});
      sb.push_back({1'b1, 8'd3});
      sb.push_back({1'b0, 8'd3});
      run_bits(1'b1, 3); run_bits(1'b0, 3); run_bits(1'b1, 3);
      run_bits(1'b0, 3); run_bits(1'b1, 3);
      flush(8);
      chk("t4_ovf",       32'(overflow),             32'd1);
      chk("t4_cnt_sum",   32'(ones_cnt + zeros_cnt), 32'd4);
      chk("t4_ones",      32'(ones_cnt),             32'd2);
      chk("t4_valid",     32'(evt_valid),            32'd1);
      chk("t4_hold_pol",  32'(evt_pol),              32'd1);
      chk("t4_hold_len",  32'(evt_len),              32'd3);
      evt_ready = 1'b1;
      flush(8);
      chk_drained("t4");

      // Full FIFO: run end and pop on the same edge, nothing dropped
      do_reset();
      evt_ready = 1'b0;
      sb.push_back({1'b1, 8'd3});
      sb.push_back({1'b0, 8'd3});
      sb.push_back({1'b1, 8'd3});
      sb.push_back({1'b0, 8'd3});
      sb.push_back({1'b1, 8'd3});
      run_bits(1'b1, 3); run_bits(1'b0, 3); run_bits(1'b1, 3);
      run_bits(1'b0, 3); run_bits(1'b1, 3);
      step(1'b0);
      chk("t5_full_valid", 32'(evt_valid), 32'd1);
      evt_ready = 1'b1;
      step(1'b1);
      flush(10);
      chk("t5_ovf",   32'(overflow),  32'd0);
      chk("t5_ones",  32'(ones_cnt),  32'd3);
      chk("t5_zeros", 32'(zeros_cnt), 32'd2);
      chk_drained("t5");

      // Reset in the middle of a run, with a record still held
      evt_ready = 1'b0;
      run_bits(~last_bit, 3);
      flush(3);
      chk("t6_held", 32'(evt_valid), 32'd1);
      run_bits(~last_bit, 5);
      chk("t6_in_run", 32'(det_y), 32'd1);
      reset = 1'b1;
      step(last_bit);
      step(last_bit);
      reset = 1'b0;
      evt_ready = 1'b1;
      flush(6);
      chk_reset_vals("t6");
      chk("t6_sb_left", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/run_event_monitor.md
# run_event_monitor

Downstream consumer of the three-in-a-row run detector. It watches the detector's Moore output `det_y` together with the same serial bit stream `x_in`. For each completed run of three or more identical bits, it measures the run length and records its polarity. Each finished run is pushed as a record into a small event FIFO with a valid/ready read port, and the block also keeps per-polarity run counters and an overflow flag.

## Interface
- `DEPTH`, 4: event FIFO depth in records; must be a power of two, minimum 2.
- `LEN_W`, 8: run-length field width; lengths saturate at 2^LEN_W−1.
- `CNT_W`, 16: width of each run counter; counters saturate at all-ones.

Ports:
- `clk`, in, 1: clock; all state changes on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `x_in`, in, 1: serial bit stream, the same stream fed to the detector.
- `det_y`, in, 1: detector output; high while the current run is at least 3 long.
- `clr`, in, 1: synchronous clear of counters, `overflow` and `max_len`. It does not clear the FIFO.
- `evt_valid`, out, 1: FIFO head record is valid.
- `evt_ready`, in, 1: consumer accepts the head record.
- `evt_pol`, out, 1: head record polarity; 1 = run of ones, 0 = run of zeros.
- `evt_len`, out, LEN_W: head record run length.
- `ones_cnt`, out, CNT_W: number of completed runs of ones pushed.
- `zeros_cnt`, out, CNT_W: number of completed runs of zeros pushed.
- `overflow`, out, 1: sticky; set when a record is dropped because the FIFO is full.
- `max_len`, out, LEN_W: longest run length seen (see Configuration).

## Operation
- Internal registers:
  - `x_q`: `x_in` delayed one cycle.
  - `y_q`: `det_y` delayed one cycle.
  - `hi_cnt`: LEN_W bits, saturating.
  - `pol`: captured polarity of the current run.
- Run-tracker FSM, two states:
  - **IDLE → RUN** on an edge where `det_y`=1. At that edge `hi_cnt`←1 and `pol`←`x_q`. `x_q` holds the bit that completed the third repeat.
  - **RUN, while `det_y`=1:** `hi_cnt`←`hi_cnt`+1, saturating.
  - **RUN → IDLE** on an edge where `det_y`=0. This is the run end; the block attempts a push of {`pol`, sat(`hi_cnt`+2)}.
- Length rule: run length = number of `det_y`-high cycles + 2, saturating at 2^LEN_W−1.
- A successful push increments `ones_cnt` or `zeros_cnt` according to `pol`.
- FIFO full at the push:
  - The record is dropped and `overflow` is set.
  - Counters do not increment.
  - If a pop occurs on the same edge, a full FIFO accepts the push and nothing is dropped.
- Pop: an edge with `evt_valid` && `evt_ready`. Records leave the FIFO in arrival order.
- `clr` and a run end on the same edge:
  - `clr` wins for the counters and `overflow`.
  - The record is still pushed if the FIFO has space.
- A run still open (RUN state) is not reported until `det_y` falls.

## Timing
- Reset values:
  - `evt_valid`=0, `evt_pol`=0, `evt_len`=0.
  - Counters = 0, `overflow`=0, `max_len`=0.
  - FSM = IDLE, FIFO empty.
  - `x_q`=0, `y_q`=0, `hi_cnt`=0, `pol`=0.
- Latency: a push occurs at the edge ending the first `det_y`-low cycle after a run; `evt_valid` rises in the following cycle.
  - Example: 1,1,1,0 gives one `det_y`-high cycle C, a push at the end of C+1, and `evt_valid` high in C+2.
- FIFO outputs are registered: `evt_pol` and `evt_len` are stable while `evt_valid`=1 and `evt_ready`=0.
- Counter updates are visible the cycle after the push.
- Reset mid-run discards the partial run and clears all FIFO contents.

## Configuration
- Macro `RUN_MON_MAXLEN_EN`.
- Defined:
  - `max_len` updates to the pushed length when that length exceeds the current value.
  - Dropped records do not update `max_len`.
  - `clr` sets `max_len` to 0.
- Undefined: no tracking logic is built, and `max_len` is tied to 0.

## Structure
- Package `run_mon_pkg` holds:
  - Polarity constants `POL_ZERO`=0 and `POL_ONE`=1.
  - FSM state constants for IDLE and RUN.
  - Default widths `LEN_W_DEF` and `CNT_W_DEF`.
  - The record packing order: {pol, len}, with pol as the MSB.
- Sub-module `run_evt_fifo`:
  - Synchronous FIFO, DEPTH × (LEN_W+1).
  - Ports: push, push data, pop, head data, full, empty.
  - Pointer-based, with an extra wrap bit for the full/empty distinction.
- The top level contains the tracker FSM, the counters and the `max_len` logic.

## Test plan
- Stream 0,1,1,1,0,0 with `evt_ready`=1 → one record {pol=1, len=3}; `ones_cnt`=1, `zeros_cnt`=0.
- Stream 0,0,0,0,0,1 → record {pol=0, len=5}; `zeros_cnt`=1; with the macro defined, `max_len`=5.
- Run of 300 ones with LEN_W=8 → `evt_len`=255 (saturated); `ones_cnt`=1.
- `evt_ready`=0 and DEPTH=4, then 5 runs of 3 → 4 records held, `overflow`=1, `ones_cnt`+`zeros_cnt`=4. Then `evt_ready`=1 → the 4 records drain in arrival order.
- FIFO full with a run end on the same edge as a pop → no drop; `overflow` stays 0.
- Reset asserted during a `det_y`-high run, then released → no record produced; all outputs are at their reset values.
